// File: rtl/regfile_scoreboard.sv
// Register file with writeback bypass and per-register pending-write counters.
// Generates the issue stall for RAW hazards against in-flight writes.
module regfile_scoreboard #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RD     = 2,
  parameter int PIPE_DEPTH = 3,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt_sys,
  input  logic                     issue_valid,
  input  logic [NUM_RD*AW-1:0]     issue_rd_addr,
  input  logic [NUM_RD-1:0]        issue_rd_used,
  input  logic                     issue_wr_en,
  input  logic [AW-1:0]            issue_wr_addr,
  input  logic                     issue_r0_en,
  output logic                     stall,
  output logic                     issue_fire,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_r0_en,
  input  logic [DATA_W-1:0]        wb_r0_data,
  input  logic                     wb_kill,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     sb_err
);

  logic [DATA_W-1:0] regs    [NUM_REGS];
  logic [CW-1:0]     cnt     [NUM_REGS];
  logic [CW-1:0]     cnt_nxt [NUM_REGS];

  logic                wr_main;
  logic                wr_r0;
  logic                hazard;
  logic                err_set;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] hz;

  assign wr_main = wb_en & ~wb_kill & ~halt_sys;
  assign wr_r0   = wb_r0_en & ~wb_kill & ~halt_sys;

  // A register hazards unless its last pending write lands this cycle.
  always_comb begin
    wb_hit   = '0;
    hz       = '0;
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wb_hit[i]   = (wr_main & (wb_addr == AW'(i)))
                  | (wr_r0 & (i == 0));
      busy_vec[i] = (cnt[i] != '0);
      hz[i]       = busy_vec[i]
                  & ~((cnt[i] == CW'(1)) & wb_hit[i]);
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (issue_rd_used[k] && hz[issue_rd_addr[k*AW +: AW]])
        hazard = 1'b1;
    end
  end

  assign stall      = halt_sys | (issue_valid & hazard);
  assign issue_fire = issue_valid & ~stall;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs[issue_rd_addr[k*AW +: AW]];
      if (wr_main && wb_addr == issue_rd_addr[k*AW +: AW])
        rd_data[k*DATA_W +: DATA_W] = wb_data;
      if (wr_r0 && issue_rd_addr[k*AW +: AW] == '0)
        rd_data[k*DATA_W +: DATA_W] = wb_r0_data;
    end
  end

  // Multiple hits on one register collapse to a single +1 / -1.
  always_comb begin
    err_set = 1'b0;
    inc     = '0;
    dec     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue_fire
             & ((issue_wr_en & (issue_wr_addr == AW'(i)))
             | (issue_r0_en & (i == 0)));
      dec[i] = (wb_en & (wb_addr == AW'(i)))
             | (wb_r0_en & (i == 0));
      cnt_nxt[i] = cnt[i];
      if (inc[i] && !dec[i]) begin
        if (cnt[i] == CW'(PIPE_DEPTH))
          err_set = 1'b1;
        else
          cnt_nxt[i] = cnt[i] + CW'(1);
      end else if (dec[i] && !inc[i]) begin
        if (cnt[i] == '0)
          err_set = 1'b1;
        else
          cnt_nxt[i] = cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (!halt_sys && err_set)
        sb_err <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!halt_sys)
          cnt[i] <= cnt_nxt[i];
        if (wr_r0 && i == 0)
          regs[i] <= wb_r0_data;
        else if (wr_main && wb_addr == AW'(i))
          regs[i] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard.
// Rows drive one cycle each; outputs are sampled on the falling edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst, halt_sys, issue_valid;
  logic [7:0]  issue_rd_addr;
  logic [1:0]  issue_rd_used;
  logic        issue_wr_en, issue_r0_en;
  logic [3:0]  issue_wr_addr;
  logic        stall, issue_fire;
  logic [31:0] rd_data;
  logic        wb_en, wb_r0_en, wb_kill;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data, wb_r0_data;
  logic [15:0] busy_vec;
  logic        sb_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr),
    .issue_rd_used(issue_rd_used), .issue_wr_en(issue_wr_en),
    .issue_wr_addr(issue_wr_addr), .issue_r0_en(issue_r0_en),
    .stall(stall), .issue_fire(issue_fire), .rd_data(rd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_r0_en(wb_r0_en), .wb_r0_data(wb_r0_data),
    .wb_kill(wb_kill), .busy_vec(busy_vec), .sb_err(sb_err)
  );

  typedef struct {
    logic        rst, halt, iv;
    logic [3:0]  ra0, ra1;
    logic [1:0]  used;
    logic        iwe;
    logic [3:0]  iwa;
    logic        ir0, wbe;
    logic [3:0]  wba;
    logic [15:0] wbd;
    logic        wr0e;
    logic [15:0] wr0d;
    logic        kill, chk;
    logic        e_stall, e_fire;
    logic [15:0] e_rd0, e_rd1, e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    logic rs, logic h, logic iv, logic [3:0] a0, logic [3:0] a1,
    logic [1:0] u, logic iwe, logic [3:0] iwa, logic ir0,
    logic wbe, logic [3:0] wba, logic [15:0] wbd,
    logic wr0e, logic [15:0] wr0d, logic kill, logic chk,
    logic es, logic ef, logic [15:0] e0, logic [15:0] e1,
    logic [15:0] eb, logic ee);
    vec_t x;
    x.rst = rs; x.halt = h; x.iv = iv; x.ra0 = a0; x.ra1 = a1;
    x.used = u; x.iwe = iwe; x.iwa = iwa; x.ir0 = ir0;
    x.wbe = wbe; x.wba = wba; x.wbd = wbd;
    x.wr0e = wr0e; x.wr0d = wr0d; x.kill = kill; x.chk = chk;
    x.e_stall = es; x.e_fire = ef; x.e_rd0 = e0; x.e_rd1 = e1;
    x.e_busy = eb; x.e_err = ee;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    rst = x.rst; halt_sys = x.halt; issue_valid = x.iv;
    issue_rd_addr = {x.ra1, x.ra0}; issue_rd_used = x.used;
    issue_wr_en = x.iwe; issue_wr_addr = x.iwa; issue_r0_en = x.ir0;
    wb_en = x.wbe; wb_addr = x.wba; wb_data = x.wbd;
    wb_r0_en = x.wr0e; wb_r0_data = x.wr0d; wb_kill = x.kill;
  endtask

  task automatic step(vec_t x, string tag);
    @(posedge clk);
    #1;
    drive(x);
    @(negedge clk);
    if (x.chk) begin
      check({tag, ".stall"}, 32'(stall), 32'(x.e_stall));
      check({tag, ".fire"}, 32'(issue_fire), 32'(x.e_fire));
      check({tag, ".rd0"}, 32'(rd_data[15:0]), 32'(x.e_rd0));
      check({tag, ".rd1"}, 32'(rd_data[31:16]), 32'(x.e_rd1));
      check({tag, ".busy"}, 32'(busy_vec), 32'(x.e_busy));
      check({tag, ".err"}, 32'(sb_err), 32'(x.e_err));
    end
  endtask

  // Shorthands for hand-written sequences (no table check).
  function automatic vec_t idle(logic [3:0] a0);
    return v(0,0,0,a0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endfunction
  function automatic vec_t iss(logic [3:0] wa);
    return v(0,0,1,0,0,0,1,wa,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endfunction
  function automatic vec_t wbrd(logic [3:0] a, logic [15:0] d);
    return v(0,0,1,a,0,2'b01,0,0,0,1,a,d,0,0,0,0, 0,0,0,0,0,0);
  endfunction

  initial begin
    drive(idle(0));
    rst = 1'b1;
    // rst hlt iv a0 a1 us iwe iwa ir0 wbe wba wbd wr0e wr0d kill chk
    //   stall fire rd0 rd1 busy err
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,
                    0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,5,0,0,0,0,0,1,5,16'h1234,0,0,0,1,
                    0,0,16'h1234,0,0,0));
    tbl.push_back(v(0,0,0,5,5,0,0,0,0,0,0,0,0,0,0,1,
                    0,0,16'h1234,16'h1234,0,1));
    tbl.push_back(v(1,0,0,5,0,0,0,0,0,0,0,0,0,0,0,1,
                    0,0,16'h1234,0,0,1));
    tbl.push_back(v(0,0,1,5,0,0,1,3,0,0,0,0,0,0,0,1,
                    0,1,0,0,0,0));
    tbl.push_back(v(0,0,1,3,0,2'b01,0,0,0,0,0,0,0,0,0,1,
                    1,0,0,0,16'h0008,0));
    tbl.push_back(v(0,0,1,3,0,2'b01,0,0,0,0,0,0,0,0,0,1,
                    1,0,0,0,16'h0008,0));
    tbl.push_back(v(0,0,1,3,0,2'b01,0,0,0,1,3,16'h5A5A,0,0,0,1,
                    0,1,16'h5A5A,0,16'h0008,0));
    tbl.push_back(v(0,0,0,3,0,0,0,0,0,0,0,0,0,0,0,1,
                    0,0,16'h5A5A,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,1,2,1,0,0,0,0,0,0,1,
                    0,1,0,0,0,0));
    tbl.push_back(v(0,0,1,0,2,2'b11,0,0,0,0,0,0,0,0,0,1,
                    1,0,0,0,16'h0005,0));
    tbl.push_back(v(0,0,1,0,2,2'b11,0,0,0,1,2,16'h00AA,1,16'hBEEF,0,1,
                    0,1,16'hBEEF,16'h00AA,16'h0005,0));
    tbl.push_back(v(0,0,0,0,2,0,0,0,0,0,0,0,0,0,0,1,
                    0,0,16'hBEEF,16'h00AA,0,0));
    tbl.push_back(v(0,0,1,0,2,0,1,0,1,0,0,0,0,0,0,1,
                    0,1,16'hBEEF,16'h00AA,0,0));
    tbl.push_back(v(0,0,0,0,2,0,0,0,0,1,0,16'h1111,1,16'h2222,0,1,
                    0,0,16'h2222,16'h00AA,16'h0001,0));
    tbl.push_back(v(0,0,0,0,2,0,0,0,0,0,0,0,0,0,0,1,
                    0,0,16'h2222,16'h00AA,0,0));
    tbl.push_back(v(0,0,1,7,0,0,1,7,0,0,0,0,0,0,0,1,
                    0,1,0,16'h2222,0,0));
    tbl.push_back(v(0,0,1,7,0,0,1,7,0,1,7,16'h0001,0,0,0,1,
                    0,1,16'h0001,16'h2222,16'h0080,0));
    tbl.push_back(v(0,0,1,7,0,2'b01,0,0,0,1,7,16'hFFFF,0,0,1,1,
                    1,0,16'h0001,16'h2222,16'h0080,0));
    tbl.push_back(v(0,0,1,7,0,2'b01,0,0,0,0,0,0,0,0,0,1,
                    0,1,16'h0001,16'h2222,0,0));

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Saturation: four issues to R1 leave exactly three pending.
    for (int i = 0; i < 4; i++) step(iss(1), "sat_iss");
    step(idle(1), "sat_idle");
    check("sat.busy", 32'(busy_vec), 32'h0002);
    check("sat.err", 32'(sb_err), 32'h1);
    step(wbrd(1, 16'h0011), "sat_wb1");
    check("sat.wb1_stall", 32'(stall), 32'h1);
    step(wbrd(1, 16'h0022), "sat_wb2");
    check("sat.wb2_stall", 32'(stall), 32'h1);
    check("sat.wb2_busy", 32'(busy_vec), 32'h0002);
    step(wbrd(1, 16'h0033), "sat_wb3");
    check("sat.wb3_stall", 32'(stall), 32'h0);
    check("sat.wb3_rd", 32'(rd_data[15:0]), 32'h0033);
    step(idle(1), "sat_done");
    check("sat.done_busy", 32'(busy_vec), 32'h0);

    // Underflow after reset.
    step(v(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst2");
    step(idle(1), "post_rst");
    check("rst2.err", 32'(sb_err), 32'h0);
    check("rst2.rd", 32'(rd_data[15:0]), 32'h0);
    step(v(0,0,0,0,0,0,0,0,0,1,4,16'h0004,0,0,0,0,0,0,0,0,0,0), "uf_wb");
    step(idle(4), "uf_idle");
    check("uf.busy", 32'(busy_vec), 32'h0);
    check("uf.err", 32'(sb_err), 32'h1);

    // Halt freezes array, counters and error flag.
    step(v(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst3");
    step(iss(6), "halt_iss");
    step(v(0,1,1,6,0,0,1,9,0,1,6,16'hDEAD,0,0,0,0,0,0,0,0,0,0), "halt");
    check("halt.stall", 32'(stall), 32'h1);
    check("halt.fire", 32'(issue_fire), 32'h0);
    check("halt.rd", 32'(rd_data[15:0]), 32'h0);
    step(idle(6), "halt_after");
    check("halt.after_rd", 32'(rd_data[15:0]), 32'h0);
    check("halt.after_busy", 32'(busy_vec), 32'h0040);
    check("halt.after_err", 32'(sb_err), 32'h0);
    step(v(0,0,0,6,0,0,0,0,0,1,6,16'h6666,0,0,0,0,0,0,0,0,0,0), "rel_wb");
    step(idle(6), "rel_idle");
    check("rel.busy", 32'(busy_vec), 32'h0);
    check("rel.rd", 32'(rd_data[15:0]), 32'h6666);
    check("rel.err", 32'(sb_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with an integrated write scoreboard for the in-order CPU pipeline. It provides `NUM_RD` read ports with writeback bypass and a primary writeback port. A dedicated R0 side-write port carries the upper half of mul/div results. Each register has a pending-write counter, which lets the block generate the issue stall itself instead of relying on a separate hazard comparator. It sits in stage 1, between instruction decode and the stage-1 pipeline register, and is written from the final pipeline stage.

## Interface
- `DATA_W`, 16, register width in bits
- `NUM_REGS`, 16, number of registers; `AW = $clog2(NUM_REGS)`
- `NUM_RD`, 2, number of read ports
- `PIPE_DEPTH`, 3, maximum in-flight writes per register; `CW = $clog2(PIPE_DEPTH+1)`
- `clk  in  1  clock; all state updates on rising edge`
- `rst  in  1  reset; synchronous, active-high`
- `halt_sys  in  1  freeze: no array write, no counter change`
- `issue_valid  in  1  decoded instruction requests issue`
- `issue_rd_addr  in  NUM_RD*AW  source register addresses, port k at [k*AW +: AW]`
- `issue_rd_used  in  NUM_RD  per-port flag: source is actually read`
- `issue_wr_en  in  1  instruction will write `issue_wr_addr``
- `issue_wr_addr  in  AW  destination register`
- `issue_r0_en  in  1  instruction will also write R0 (mul/div high half)`
- `stall  out  1  issue blocked this cycle`
- `issue_fire  out  1  issue_valid & ~stall`
- `rd_data  out  NUM_RD*DATA_W  read data, bypassed`
- `wb_en  in  1  writeback of `wb_data` to `wb_addr``
- `wb_addr  in  AW  writeback destination`
- `wb_data  in  DATA_W  writeback data`
- `wb_r0_en  in  1  writeback of `wb_r0_data` to R0`
- `wb_r0_data  in  DATA_W  R0 side data`
- `wb_kill  in  1  cancel the writeback slot: the counters of `wb_addr` (if `wb_en`) and of R0 (if `wb_r0_en`) still decrement; the array is not written`
- `busy_vec  out  NUM_REGS  bit i = pending count of reg i nonzero`
- `sb_err  out  1  sticky: counter overflow or underflow attempted`

## Operation
- **Array.** `NUM_REGS` x `DATA_W` flops.
  - A write occurs when `wb_en & ~wb_kill & ~halt_sys`, and when `wb_r0_en & ~wb_kill & ~halt_sys` for R0.
  - If `wb_en` targets R0 and `wb_r0_en` is also high, R0 takes `wb_r0_data`.
- **Read.** `rd_data[k]` is combinational.
  - It returns the array value, overridden by the data being written this cycle to the same address, using the same priority as the array write.
  - The bypass is suppressed by `wb_kill` or `halt_sys`.
- **Pending counters.** `cnt[i]`, `CW` bits, one per register.
  - Increment: `issue_fire & issue_wr_en` for `issue_wr_addr`; `issue_fire & issue_r0_en` for R0.
  - Decrement: `wb_en` for `wb_addr`; `wb_r0_en` for R0. Decrements apply even when `wb_kill` is high.
  - If the same register would get more than one increment or more than one decrement in a cycle, it takes at most +1 and −1 in total. Simultaneous +1 and −1 leave the count unchanged.
  - Increment at `PIPE_DEPTH` saturates the counter and sets `sb_err`.
  - Decrement at 0 holds the counter at 0 and sets `sb_err`.
  - `halt_sys` blocks every update.
- **Stall.** `stall = halt_sys | (issue_valid & hazard)`.
  - `hazard`: some port k with `issue_rd_used[k]` and effective count of `issue_rd_addr[k]` > 0.
  - Effective count = `cnt` − 1 when that register is being written back this cycle (non-killed), else `cnt`.
  - A killed writeback does not clear a hazard in its own cycle.
- **R0 scope.** Address 0 is an ordinary register for reads. R0 is tracked by the same counter whether it is written through the main port or the side port.
- **Order.** Writes are in order; no WAW check. A destination with a nonzero count does not stall.

## Timing
- **Reset.** One `rst` edge zeroes the array, all counters and `sb_err`.
  - Outputs after reset: `busy_vec` = 0, `rd_data` = 0, `stall` = `halt_sys`, `issue_fire` = `issue_valid & ~halt_sys`.
  - `rst` overrides `halt_sys` and all same-cycle writes or issues.
  - Reset mid-operation discards every pending count, and late writebacks then flag `sb_err`.
- **Read latency.** A writeback is visible on `rd_data` in the same cycle via bypass and from the array after the edge.
- **Scoreboard latency.** A counter and its `busy_vec` bit update on the edge after `issue_fire` or the writeback.
  - The stall decision uses pre-edge counts plus same-cycle writeback.
  - Issue-then-read back-to-back therefore stalls until the matching writeback cycle.
- **Combinational path.** `stall` and `issue_fire` are combinational from the inputs. There is no combinational path from `issue_*` to `rd_data`, except through the address select.

## Test plan
- **Reset and read.** Assert `rst`, then write R5=`16'h1234` via `wb_en`; read port 0 at addr 5 in the same cycle.
  - Required: `rd_data` = `16'h1234` via bypass in that cycle and from the array next cycle; `busy_vec` = 0.
- **RAW stall.** Issue a write to R3 (`cnt[3]` → 1). Next cycle, issue a read of R3.
  - Required: `stall` = 1 until the cycle `wb_en`/`wb_addr`=3 arrives. In that cycle `stall` = 0 and `rd_data` = `wb_data`. The following cycle `busy_vec[3]` = 0.
- **R0 side port.** Issue with `issue_r0_en` and `issue_wr_addr`=2, then write back `wb_data`=`16'h00AA` and `wb_r0_data`=`16'hBEEF`.
  - Required: R2=`00AA`, R0=`BEEF`, and both counters return to 0.
  - Also: `wb_addr`=0 together with `wb_r0_en` gives R0=`wb_r0_data`.
- **Kill.** Pending R7, with R7=`16'h0001` before the writeback; then `wb_en`, `wb_addr`=7, `wb_kill`, `wb_data`=`16'hFFFF`.
  - Required: R7 keeps `0001`; `cnt[7]` → 0. A read of R7 in the kill cycle still stalls.
- **Saturation and underflow.** Issue 4 writes to R1 with `PIPE_DEPTH`=3.
  - Required: `cnt[1]` = 3 and `sb_err` = 1.
  - Then `rst`, then a `wb_en` to R4: `cnt[4]` stays 0 and `sb_err` = 1.
- **Halt.** Pending R6, then `halt_sys` = 1 with a simultaneous writeback to R6 and `issue_valid`.
  - Required: array, counters and `sb_err` unchanged; `stall` = 1; `issue_fire` = 0.
